// File: rtl/tick_bcd_display.sv
// Latches a 7-bit count, converts it to BCD serially and scans H/T/U/blank onto one 7-segment digit.
// Latency: a load reaches the display registers 8 clk after capture; a queued value takes 8 more.
// Backpressure: none; loads during conversion go to a 1-deep last-write-wins slot, busy_o shows it.
module tick_bcd_display #(
    parameter int DWELL    = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [6:0] value_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] digit_sel_o,
    output logic       busy_o
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } conv_state_t;

    typedef enum logic [1:0] {
        PH_H     = 2'd0,
        PH_T     = 2'd1,
        PH_U     = 2'd2,
        PH_BLANK = 2'd3
    } phase_t;

    conv_state_t     state;
    logic [2:0]      step;
    logic [11:0]     bcd;
    logic [6:0]      bin;
    logic            pend_vld;
    logic [6:0]      pend_dat;
    logic [3:0]      disp_h;
    logic [3:0]      disp_t;
    logic [3:0]      disp_u;
    phase_t          phase;
    logic [DW-1:0]   dwell;
    logic [11:0]     bcd_adj;

    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign bcd_adj = {nib_adj(bcd[11:8]), nib_adj(bcd[7:4]), nib_adj(bcd[3:0])};

    // Conversion FSM: 7 add-3/shift steps, then one commit edge that may chain the next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step     <= 3'd0;
            bcd      <= 12'd0;
            bin      <= 7'd0;
            pend_vld <= 1'b0;
            pend_dat <= 7'd0;
            disp_h   <= 4'd0;
            disp_t   <= 4'd0;
            disp_u   <= 4'd0;
            busy_o   <= 1'b0;
        end else if (ena) begin
            case (state)
                S_IDLE: begin
                    if (load_i) begin
                        bin    <= value_i;
                        bcd    <= 12'd0;
                        step   <= 3'd0;
                        state  <= S_CONV;
                        busy_o <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (step != 3'd7) begin
                        bcd  <= {bcd_adj[10:0], bin[6]};
                        bin  <= {bin[5:0], 1'b0};
                        step <= step + 3'd1;
                        if (load_i) begin
                            pend_vld <= 1'b1;
                            pend_dat <= value_i;
                        end
                    end else begin
                        disp_h <= bcd[11:8];
                        disp_t <= bcd[7:4];
                        disp_u <= bcd[3:0];
                        bcd    <= 12'd0;
                        step   <= 3'd0;
                        // A load on the commit edge supersedes anything queued.
                        if (load_i) begin
                            bin      <= value_i;
                            pend_vld <= 1'b0;
                            busy_o   <= 1'b1;
                        end else if (pend_vld) begin
                            bin      <= pend_dat;
                            pend_vld <= 1'b0;
                            busy_o   <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display sequencer: free-running on tick_i, untouched by loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_H;
            dwell <= '0;
        end else if (ena && tick_i) begin
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                phase <= phase_t'(phase + 2'd1);
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign digit_sel_o = phase;

    always_comb begin
        seg_o = 7'h00;
        dp_o  = 1'b0;
        if (ena) begin
            case (phase)
                PH_H: begin
                    if (!(BLANK_LZ && disp_h == 4'd0))
                        seg_o = seg7(disp_h);
                end
                PH_T: begin
                    if (!(BLANK_LZ && disp_h == 4'd0 && disp_t == 4'd0))
                        seg_o = seg7(disp_t);
                end
                PH_U: begin
                    seg_o = seg7(disp_u);
                    dp_o  = 1'b1;
                end
                default: seg_o = 7'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_bcd_display.sv
// Directed bench for tick_bcd_display: scan sequence, conversion, queuing, reset and enable.
module tb_tick_bcd_display;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       tick_i;
    logic       load_i;
    logic [6:0] value_i;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [1:0] digit_sel_o;
    logic       busy_o;
    logic [6:0] seg0_o;
    logic       dp0_o;
    logic [1:0] digit_sel0_o;
    logic       busy0_o;

    int total;
    int bad;

    tick_bcd_display #(.DWELL(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick_i(tick_i), .load_i(load_i),
        .value_i(value_i), .seg_o(seg_o), .dp_o(dp_o), .digit_sel_o(digit_sel_o),
        .busy_o(busy_o)
    );

    tick_bcd_display #(.DWELL(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick_i(tick_i), .load_i(load_i),
        .value_i(value_i), .seg_o(seg0_o), .dp_o(dp0_o), .digit_sel_o(digit_sel0_o),
        .busy_o(busy0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    task automatic goto_phase(input logic [1:0] p);
        for (int i = 0; i < 24 && digit_sel_o != p; i++) do_tick();
        total++;
        if (digit_sel_o !== p) begin
            bad++;
            $display("FAIL goto_phase: got %0d expected %0d", digit_sel_o, p);
        end
    endtask

    task automatic load_and_wait(input logic [6:0] v);
        int n;
        load_i  = 1'b1;
        value_i = v;
        step();
        load_i  = 1'b0;
        n = 0;
        while (busy_o && n < 40) begin
            step();
            n++;
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL load_wait_timeout: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        total++;
        if (seg_o !== 7'h00 || dp_o !== 1'b0 || digit_sel_o !== 2'd0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: seg=%h dp=%b sel=%0d busy=%b expected 00 0 0 0",
                     seg_o, dp_o, digit_sel_o, busy_o);
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [5];
        logic [1:0] exp_sel [5];
        exp_seg[0] = 7'h00; exp_sel[0] = 2'd0;
        exp_seg[1] = 7'h00; exp_sel[1] = 2'd1;
        exp_seg[2] = 7'h3F; exp_sel[2] = 2'd2;
        exp_seg[3] = 7'h00; exp_sel[3] = 2'd3;
        exp_seg[4] = 7'h00; exp_sel[4] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) repeat (4) do_tick();
            total++;
            if (seg_o !== exp_seg[k] || digit_sel_o !== exp_sel[k] || dp_o !== (k == 2)) begin
                bad++;
                $display("FAIL scan_%0d: seg=%h sel=%0d dp=%b expected %h %0d %b",
                         k * 4, seg_o, digit_sel_o, dp_o, exp_seg[k], exp_sel[k], k == 2);
            end
        end
        // Three ticks inside one dwell must not move the phase.
        repeat (3) do_tick();
        total++;
        if (digit_sel_o !== 2'd0) begin
            bad++;
            $display("FAIL scan_dwell: sel=%0d expected 0", digit_sel_o);
        end
        do_tick();
    endtask

    task automatic test_convert_127();
        int cnt;
        load_i  = 1'b1;
        value_i = 7'd127;
        step();
        load_i  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_o) cnt++;
            step();
        end
        total++;
        if (cnt != 8) begin
            bad++;
            $display("FAIL busy_len_127: got %0d cycles expected 8", cnt);
        end
        goto_phase(2'd0);
        total++;
        if (seg_o !== 7'h06) begin bad++; $display("FAIL h_127: got %h expected 06", seg_o); end
        goto_phase(2'd1);
        total++;
        if (seg_o !== 7'h5B) begin bad++; $display("FAIL t_127: got %h expected 5B", seg_o); end
        goto_phase(2'd2);
        total++;
        if (seg_o !== 7'h07 || dp_o !== 1'b1) begin
            bad++;
            $display("FAIL u_127: got %h dp %b expected 07 1", seg_o, dp_o);
        end
    endtask

    task automatic test_leading_zero();
        load_and_wait(7'd5);
        goto_phase(2'd0);
        total++;
        if (seg_o !== 7'h00 || seg0_o !== 7'h3F) begin
            bad++;
            $display("FAIL lz_h: got %h/%h expected 00/3F", seg_o, seg0_o);
        end
        goto_phase(2'd1);
        total++;
        if (seg_o !== 7'h00 || seg0_o !== 7'h3F) begin
            bad++;
            $display("FAIL lz_t: got %h/%h expected 00/3F", seg_o, seg0_o);
        end
        goto_phase(2'd2);
        total++;
        if (seg_o !== 7'h6D || seg0_o !== 7'h6D) begin
            bad++;
            $display("FAIL lz_u: got %h/%h expected 6D/6D", seg_o, seg0_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg;
        // Parked on the units phase with no ticks, so seg_o tracks the units register.
        for (int e = 0; e <= 20; e++) begin
            load_i  = (e == 0 || e == 3 || e == 5);
            value_i = (e == 0) ? 7'd42 : (e == 3) ? 7'd99 : 7'd64;
            step();
            load_i = 1'b0;
            exp_seg = (e < 8) ? 7'h6D : (e < 16) ? 7'h5B : 7'h66;
            total++;
            if (busy_o !== (e <= 15)) begin
                bad++;
                $display("FAIL b2b_busy_e%0d: got %b expected %b", e, busy_o, e <= 15);
            end
            total++;
            if (seg_o !== exp_seg) begin
                bad++;
                $display("FAIL b2b_units_e%0d: got %h expected %h", e, seg_o, exp_seg);
            end
        end
        goto_phase(2'd0);
        total++;
        if (seg_o !== 7'h00) begin bad++; $display("FAIL b2b_h: got %h expected 00", seg_o); end
        goto_phase(2'd1);
        total++;
        if (seg_o !== 7'h7D) begin bad++; $display("FAIL b2b_t: got %h expected 7D", seg_o); end
        goto_phase(2'd0);
    endtask

    task automatic test_reset_mid_conv();
        load_i  = 1'b1;
        value_i = 7'd88;
        step();
        load_i  = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (seg_o !== 7'h00 || dp_o !== 1'b0 || digit_sel_o !== 2'd0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: seg=%h dp=%b sel=%0d busy=%b expected 00 0 0 0",
                     seg_o, dp_o, digit_sel_o, busy_o);
        end
        step();
        rst_n = 1'b1;
        repeat (10) step();
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        goto_phase(2'd1);
        total++;
        if (seg_o !== 7'h00) begin bad++; $display("FAIL rst_t: got %h expected 00", seg_o); end
        goto_phase(2'd2);
        total++;
        if (seg_o !== 7'h3F) begin bad++; $display("FAIL rst_u: got %h expected 3F", seg_o); end
    endtask

    task automatic test_enable();
        load_and_wait(7'd35);
        goto_phase(2'd1);
        do_tick();
        ena = 1'b0;
        #1;
        total++;
        if (seg_o !== 7'h00 || dp_o !== 1'b0 || digit_sel_o !== 2'd1) begin
            bad++;
            $display("FAIL ena_off: seg=%h dp=%b sel=%0d expected 00 0 1", seg_o, dp_o, digit_sel_o);
        end
        for (int i = 0; i < 10; i++) begin
            load_i  = (i == 2 || i == 7);
            value_i = 7'd77;
            tick_i  = 1'b1;
            step();
            load_i  = 1'b0;
            tick_i  = 1'b0;
        end
        total++;
        if (seg_o !== 7'h00 || digit_sel_o !== 2'd1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ena_hold: seg=%h sel=%0d busy=%b expected 00 1 0",
                     seg_o, digit_sel_o, busy_o);
        end
        ena = 1'b1;
        #1;
        total++;
        if (seg_o !== 7'h4F || digit_sel_o !== 2'd1) begin
            bad++;
            $display("FAIL ena_resume: seg=%h sel=%0d expected 4F 1", seg_o, digit_sel_o);
        end
        // Dwell was 1 when frozen, so two more ticks stay on tens and the third advances.
        repeat (2) do_tick();
        total++;
        if (digit_sel_o !== 2'd1) begin
            bad++;
            $display("FAIL ena_dwell_kept: sel=%0d expected 1", digit_sel_o);
        end
        do_tick();
        total++;
        if (digit_sel_o !== 2'd2 || seg_o !== 7'h6D) begin
            bad++;
            $display("FAIL ena_next_u: sel=%0d seg=%h expected 2 6D", digit_sel_o, seg_o);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        tick_i  = 1'b0;
        load_i  = 1'b0;
        value_i = 7'd0;
        test_reset();
        test_scan();
        test_convert_127();
        test_leading_zero();
        test_back_to_back();
        test_reset_mid_conv();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
